// File: rtl/riscv_exec_stage.sv
// riscv_exec_stage: single-lane execute stage with operand forwarding and a
// registered valid/ready result slot feeding writeback.
// Build option: define RISCV_EXEC_BYPASS_EN to enable the slot and writeback
// forwarding paths. When it is left undefined, register-file values are used
// as-is and the issue stage is responsible for stalling on hazards.

// Combinational integer ALU.
module riscv_alu (
    input  logic [3:0]  alu_op_i,
    input  logic [31:0] alu_a_i,
    input  logic [31:0] alu_b_i,
    output logic [31:0] alu_p_o
);
    localparam logic [3:0] ALU_NONE             = 4'b0000;
    localparam logic [3:0] ALU_SHIFTL           = 4'b0001;
    localparam logic [3:0] ALU_SHIFTR           = 4'b0010;
    localparam logic [3:0] ALU_SHIFTR_ARITH     = 4'b0011;
    localparam logic [3:0] ALU_ADD              = 4'b0100;
    localparam logic [3:0] ALU_SUB              = 4'b0110;
    localparam logic [3:0] ALU_AND              = 4'b0111;
    localparam logic [3:0] ALU_OR               = 4'b1000;
    localparam logic [3:0] ALU_XOR              = 4'b1001;
    localparam logic [3:0] ALU_LESS_THAN        = 4'b1010;
    localparam logic [3:0] ALU_LESS_THAN_SIGNED = 4'b1011;

    // Operation select; unknown codes pass operand A through.
    always_comb begin
        alu_p_o = alu_a_i;
        case (alu_op_i)
            ALU_NONE:             alu_p_o = alu_a_i;
            ALU_SHIFTL:           alu_p_o = alu_a_i << alu_b_i[4:0];
            ALU_SHIFTR:           alu_p_o = alu_a_i >> alu_b_i[4:0];
            ALU_SHIFTR_ARITH:     alu_p_o = $unsigned($signed(alu_a_i) >>> alu_b_i[4:0]);
            ALU_ADD:              alu_p_o = alu_a_i + alu_b_i;
            ALU_SUB:              alu_p_o = alu_a_i - alu_b_i;
            ALU_AND:              alu_p_o = alu_a_i & alu_b_i;
            ALU_OR:               alu_p_o = alu_a_i | alu_b_i;
            ALU_XOR:              alu_p_o = alu_a_i ^ alu_b_i;
            ALU_LESS_THAN:        alu_p_o = {31'b0, (alu_a_i < alu_b_i)};
            ALU_LESS_THAN_SIGNED: alu_p_o = {31'b0, ($signed(alu_a_i) < $signed(alu_b_i))};
            default:              alu_p_o = alu_a_i;
        endcase
    end
endmodule

module riscv_exec_stage #(
    parameter logic [31:0] RESET_RESULT = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [3:0]  in_alu_op,
    input  logic        in_sel_a,
    input  logic        in_sel_b,
    input  logic [4:0]  in_rs1_idx,
    input  logic [4:0]  in_rs2_idx,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    input  logic [31:0] in_imm,
    input  logic [4:0]  in_rd_idx,
    input  logic        in_rd_we,
    input  logic        wb_valid,
    input  logic        wb_rd_we,
    input  logic [4:0]  wb_rd_idx,
    input  logic [31:0] wb_rd_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [4:0]  out_rd_idx,
    output logic        out_rd_we,
    output logic [31:0] out_result
);
    logic        valid_q,  valid_d;
    logic [31:0] pc_q,     pc_d;
    logic [4:0]  rd_idx_q, rd_idx_d;
    logic        rd_we_q,  rd_we_d;
    logic [31:0] result_q, result_d;

    logic        accept;
    logic [31:0] rs1_fwd;
    logic [31:0] rs2_fwd;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_p;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

`ifdef RISCV_EXEC_BYPASS_EN
    // Operand forwarding: x0 never forwarded, slot beats writeback (younger data).
    always_comb begin
        rs1_fwd = in_rs1_val;
        if (in_rs1_idx == 5'd0)
            rs1_fwd = in_rs1_val;
        else if (valid_q && rd_we_q && (rd_idx_q == in_rs1_idx))
            rs1_fwd = result_q;
        else if (wb_valid && wb_rd_we && (wb_rd_idx == in_rs1_idx))
            rs1_fwd = wb_rd_val;

        rs2_fwd = in_rs2_val;
        if (in_rs2_idx == 5'd0)
            rs2_fwd = in_rs2_val;
        else if (valid_q && rd_we_q && (rd_idx_q == in_rs2_idx))
            rs2_fwd = result_q;
        else if (wb_valid && wb_rd_we && (wb_rd_idx == in_rs2_idx))
            rs2_fwd = wb_rd_val;
    end
`else
    logic unused_fwd_inputs;

    // No forwarding: register-file data is used directly.
    always_comb begin
        rs1_fwd = in_rs1_val;
        rs2_fwd = in_rs2_val;
    end

    assign unused_fwd_inputs = ^{wb_valid, wb_rd_we, wb_rd_idx, wb_rd_val,
                                 in_rs1_idx, in_rs2_idx};
`endif

    // Operand muxing in front of the ALU.
    always_comb begin
        alu_a = in_sel_a ? in_pc  : rs1_fwd;
        alu_b = in_sel_b ? in_imm : rs2_fwd;
    end

    riscv_alu u_alu (
        .alu_op_i (in_alu_op),
        .alu_a_i  (alu_a),
        .alu_b_i  (alu_b),
        .alu_p_o  (alu_p)
    );

    // Result slot next-state: flush, then accept, then drain, else hold.
    always_comb begin
        valid_d  = valid_q;
        pc_d     = pc_q;
        rd_idx_d = rd_idx_q;
        rd_we_d  = rd_we_q;
        result_d = result_q;
        if (flush) begin
            valid_d  = 1'b0;
            rd_we_d  = 1'b0;
            result_d = RESET_RESULT;
        end else if (accept) begin
            valid_d  = 1'b1;
            pc_d     = in_pc;
            rd_idx_d = in_rd_idx;
            rd_we_d  = in_rd_we && (in_rd_idx != 5'd0);
            result_d = alu_p;
        end else if (valid_q && out_ready) begin
            valid_d  = 1'b0;
        end
    end

    // Slot registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            rd_idx_q <= '0;
            rd_we_q  <= 1'b0;
            result_q <= RESET_RESULT;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            rd_idx_q <= rd_idx_d;
            rd_we_q  <= rd_we_d;
            result_q <= result_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_pc     = pc_q;
    assign out_rd_idx = rd_idx_q;
    assign out_rd_we  = rd_we_q;
    assign out_result = result_q;
endmodule

// File: tb/tb_riscv_exec_stage.sv
// Directed testbench for riscv_exec_stage; expectations follow the build's
// RISCV_EXEC_BYPASS_EN setting.
module tb_riscv_exec_stage;
    localparam logic [3:0] ALU_SHIFTL           = 4'b0001;
    localparam logic [3:0] ALU_ADD              = 4'b0100;
    localparam logic [3:0] ALU_SUB              = 4'b0110;
    localparam logic [3:0] ALU_OR               = 4'b1000;
    localparam logic [3:0] ALU_XOR              = 4'b1001;
    localparam logic [3:0] ALU_LESS_THAN_SIGNED = 4'b1011;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [31:0] in_pc;
    logic [3:0]  in_alu_op;
    logic        in_sel_a, in_sel_b;
    logic [4:0]  in_rs1_idx, in_rs2_idx;
    logic [31:0] in_rs1_val, in_rs2_val, in_imm;
    logic [4:0]  in_rd_idx;
    logic        in_rd_we;
    logic        wb_valid, wb_rd_we;
    logic [4:0]  wb_rd_idx;
    logic [31:0] wb_rd_val;
    logic        out_valid, out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rd_idx;
    logic        out_rd_we;
    logic [31:0] out_result;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    riscv_exec_stage #(.RESET_RESULT(32'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_alu_op  (in_alu_op),
        .in_sel_a   (in_sel_a),
        .in_sel_b   (in_sel_b),
        .in_rs1_idx (in_rs1_idx),
        .in_rs2_idx (in_rs2_idx),
        .in_rs1_val (in_rs1_val),
        .in_rs2_val (in_rs2_val),
        .in_imm     (in_imm),
        .in_rd_idx  (in_rd_idx),
        .in_rd_we   (in_rd_we),
        .wb_valid   (wb_valid),
        .wb_rd_we   (wb_rd_we),
        .wb_rd_idx  (wb_rd_idx),
        .wb_rd_val  (wb_rd_val),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_rd_idx (out_rd_idx),
        .out_rd_we  (out_rd_we),
        .out_result (out_result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [3:0] op,
                         input logic sa, input logic sb,
                         input logic [4:0] r1i, input logic [31:0] r1v,
                         input logic [4:0] r2i, input logic [31:0] r2v,
                         input logic [31:0] imm, input logic [4:0] rdi, input logic rdwe);
        in_valid   = 1'b1;
        in_pc      = pc;
        in_alu_op  = op;
        in_sel_a   = sa;
        in_sel_b   = sb;
        in_rs1_idx = r1i;
        in_rs1_val = r1v;
        in_rs2_idx = r2i;
        in_rs2_val = r2v;
        in_imm     = imm;
        in_rd_idx  = rdi;
        in_rd_we   = rdwe;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_pc = '0; in_alu_op = '0; in_sel_a = 1'b0; in_sel_b = 1'b0;
        in_rs1_idx = '0; in_rs2_idx = '0; in_rs1_val = '0; in_rs2_val = '0;
        in_imm = '0; in_rd_idx = '0; in_rd_we = 1'b0;
        wb_valid = 1'b0; wb_rd_we = 1'b0; wb_rd_idx = '0; wb_rd_val = '0;

        // Reset state
        step(); step();
        rst = 1'b0;
        check("rst_valid",  32'(out_valid), 32'd0);
        check("rst_pc",     out_pc, 32'd0);
        check("rst_rd_idx", 32'(out_rd_idx), 32'd0);
        check("rst_rd_we",  32'(out_rd_we), 32'd0);
        check("rst_result", out_result, 32'd0);
        check("rst_in_rdy", 32'(in_ready), 32'd1);

        // First accept: x3 = 5 + 7
        issue(32'h40, ALU_ADD, 0, 0, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 5'd3, 1);
        step();
        check("t1_valid",  32'(out_valid), 32'd1);
        check("t1_result", out_result, 32'd12);
        check("t1_rd_idx", 32'(out_rd_idx), 32'd3);
        check("t1_rd_we",  32'(out_rd_we), 32'd1);
        check("t1_pc",     out_pc, 32'h40);

        // Self-forward: x4 = x3 - 2 with stale rs1 value 0
        issue(32'h44, ALU_SUB, 0, 1, 5'd3, 32'd0, 5'd0, 32'd0, 32'd2, 5'd4, 1);
        step();
`ifdef RISCV_EXEC_BYPASS_EN
        check("t2_selffwd", out_result, 32'd10);
`else
        check("t2_selffwd", out_result, 32'hFFFF_FFFE);
`endif
        check("t2_rd_idx", 32'(out_rd_idx), 32'd4);

        // Forward priority: slot x5 = 1, writeback commits x5 = 9
        issue(32'h48, ALU_ADD, 0, 0, 5'd0, 32'd1, 5'd0, 32'd0, 32'd0, 5'd5, 1);
        step();
        check("t3_x5", out_result, 32'd1);
        wb_valid = 1'b1; wb_rd_we = 1'b1; wb_rd_idx = 5'd5; wb_rd_val = 32'd9;
        issue(32'h4C, ALU_ADD, 0, 0, 5'd5, 32'd3, 5'd0, 32'd0, 32'd0, 5'd6, 1);
        step();
`ifdef RISCV_EXEC_BYPASS_EN
        check("t3_prio", out_result, 32'd1);
`else
        check("t3_prio", out_result, 32'd3);
`endif
        // x0 read while writeback targets x0
        wb_rd_idx = 5'd0;
        issue(32'h50, ALU_ADD, 0, 0, 5'd0, 32'h55, 5'd0, 32'd0, 32'd0, 5'd7, 1);
        step();
        check("t3_x0", out_result, 32'h55);
        // Writeback-only forward on rs2
        wb_rd_idx = 5'd8; wb_rd_val = 32'h20;
        issue(32'h54, ALU_ADD, 0, 0, 5'd0, 32'd1, 5'd8, 32'd0, 32'd0, 5'd9, 1);
        step();
`ifdef RISCV_EXEC_BYPASS_EN
        check("t3_wbfwd", out_result, 32'h21);
`else
        check("t3_wbfwd", out_result, 32'h1);
`endif
        wb_valid = 1'b0; wb_rd_we = 1'b0;

        // A few more ALU ops
        issue(32'h58, ALU_SHIFTL, 0, 1, 5'd0, 32'd1, 5'd0, 32'd0, 32'd4, 5'd10, 1);
        step();
        check("op_sll", out_result, 32'd16);
        issue(32'h5C, ALU_LESS_THAN_SIGNED, 0, 0, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd0, 32'd0, 5'd10, 1);
        step();
        check("op_slt", out_result, 32'd1);

        // Back-pressure: A in slot, B blocked for 3 cycles
        issue(32'h60, ALU_ADD, 0, 0, 5'd0, 32'h10, 5'd0, 32'h1, 32'd0, 5'd9, 1);
        step();
        check("bp_a", out_result, 32'h11);
        out_ready = 1'b0;
        issue(32'h64, ALU_XOR, 0, 0, 5'd0, 32'hF0, 5'd0, 32'hFF, 32'd0, 5'd10, 1);
        #1;
        check("bp_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_res",   out_result, 32'h11);
            check("bp_hold_rd",    32'(out_rd_idx), 32'd9);
            check("bp_hold_pc",    out_pc, 32'h60);
            check("bp_hold_rdy",   32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", 32'(in_ready), 32'd1);
        step();
        check("bp_b_valid", 32'(out_valid), 32'd1);
        check("bp_b_res",   out_result, 32'h0F);
        check("bp_b_pc",    out_pc, 32'h64);
        issue(32'h68, ALU_OR, 0, 0, 5'd0, 32'h100, 5'd0, 32'h1, 32'd0, 5'd11, 1);
        step();
        check("bp_c_res", out_result, 32'h101);
        check("bp_c_rd",  32'(out_rd_idx), 32'd11);

        // Flush with full slot and an instruction presented
        out_ready = 1'b0;
        flush = 1'b1;
        issue(32'h6C, ALU_ADD, 0, 0, 5'd0, 32'd1, 5'd0, 32'd1, 32'd0, 5'd12, 1);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("fl_valid",  32'(out_valid), 32'd0);
        check("fl_rd_we",  32'(out_rd_we), 32'd0);
        check("fl_result", out_result, 32'd0);
        step();
        check("fl_dropped", 32'(out_valid), 32'd0);

        // PC-relative add with rd = x0
        issue(32'h100, ALU_ADD, 1, 1, 5'd0, 32'd0, 5'd0, 32'd0, 32'h1000, 5'd0, 1);
        step();
        in_valid = 1'b0;
        check("pcrel_result", out_result, 32'h1100);
        check("pcrel_valid",  32'(out_valid), 32'd1);
        check("x0_rd_we",     32'(out_rd_we), 32'd0);
        check("pcrel_pc",     out_pc, 32'h100);
        step();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_hold",  out_result, 32'h1100);

        // Reset mid-operation discards the slot
        issue(32'h200, ALU_ADD, 0, 0, 5'd0, 32'd3, 5'd0, 32'd4, 32'd0, 5'd13, 1);
        step();
        check("mid_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid",  32'(out_valid), 32'd0);
        check("mid_rst_result", out_result, 32'd0);
        check("mid_rst_pc",     out_pc, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/riscv_exec_stage.md
# riscv_exec_stage

Single-lane execute stage for the dual-issue in-order core; one instance per issue lane. It accepts one issued ALU instruction per cycle from the issue stage and selects its operands (register value, PC or immediate). It resolves read-after-write hazards by forwarding, drives the combinational `riscv_alu`, and registers the result into a valid/ready pipeline slot consumed by writeback.

## Interface
Parameters:
- `RESET_RESULT`, 32'h0: reset and flush value of `out_result`.

Ports (all are active-high unless noted otherwise):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  pipeline flush from branch resolution.
- `in_valid`  in  1  issue slot holds an instruction.
- `in_ready`  out  1  stage can accept the instruction this cycle.
- `in_pc`  in  32  instruction PC.
- `in_alu_op`  in  4  `ALU_*` code from riscv_def.v.
- `in_sel_a`  in  1  0 = rs1 operand, 1 = `in_pc`.
- `in_sel_b`  in  1  0 = rs2 operand, 1 = `in_imm`.
- `in_rs1_idx`, `in_rs2_idx`  in  5  source register indices.
- `in_rs1_val`, `in_rs2_val`  in  32  register-file read data.
- `in_imm`  in  32  sign-extended immediate.
- `in_rd_idx`  in  5  destination register index.
- `in_rd_we`  in  1  instruction writes rd.
- `wb_valid`  in  1  writeback is committing this cycle.
- `wb_rd_we`  in  1  the committing instruction writes rd.
- `wb_rd_idx`  in  5  rd index being committed.
- `wb_rd_val`  in  32  value being committed.
- `out_valid`  out  1  result slot full.
- `out_ready`  in  1  writeback accepts the slot.
- `out_pc`  out  32  registered PC.
- `out_rd_idx`  out  5  registered rd index.
- `out_rd_we`  out  1  registered write enable.
- `out_result`  out  32  registered ALU result.

## Operation
Acceptance and handshake:
- `in_ready = !out_valid || out_ready` (combinational, no bubble).
- An instruction is accepted when `accept = in_valid && in_ready && !flush`.

Operand resolution per source s (rs1, rs2), evaluated combinationally in the accept cycle, first match wins:
- If `s_idx == 0`, use `in_s_val` unchanged (x0 is never forwarded).
- If `out_valid && out_rd_we && out_rd_idx == s_idx`, use `out_result` (self-forward from the older instruction held in the slot).
- If `wb_valid && wb_rd_we && wb_rd_idx == s_idx`, use `wb_rd_val`.
- Otherwise use `in_s_val`.

ALU inputs and result:
- `alu_a = in_sel_a ? in_pc : rs1_fwd`.
- `alu_b = in_sel_b ? in_imm : rs2_fwd`.
- The ALU is combinational. Its result is captured into `out_result` on `accept`.

Slot register update, priority order:
- **rst**: `out_valid` = 0, `out_pc` = 0, `out_rd_idx` = 0, `out_rd_we` = 0, `out_result` = `RESET_RESULT`.
- **flush**: `out_valid` = 0, `out_rd_we` = 0, `out_result` = `RESET_RESULT`. Any instruction presented in the same cycle is dropped.
- **accept**: load all `out_*` fields and set `out_valid` = 1. `out_rd_we = in_rd_we && (in_rd_idx != 0)`.
- **`out_valid && out_ready`** without accept: `out_valid` = 0. The other fields hold.
- **Otherwise**: hold all fields.

## Timing
- Latency: 1 cycle. An instruction accepted at edge N appears with `out_valid` = 1 after edge N.
- Throughput: 1 instruction per cycle while `out_ready` = 1.
- Back-pressure: with `out_valid` = 1 and `out_ready` = 0, `in_ready` = 0 and all outputs stay stable until drained.
- Drain and refill happen in the same cycle with no bubble.
- A flush takes effect at the next edge.
- Reset mid-operation discards the slot. Its contents never reach writeback.

## Configuration
Macro `RISCV_EXEC_BYPASS_EN`:
- **Defined**: both forwarding paths are active, exactly as described under Operation.
- **Undefined**: `rs1_fwd = in_rs1_val` and `rs2_fwd = in_rs2_val`. The `wb_*` inputs are ignored, and the issue stage must stall on hazards.
- All other behaviour is identical in both builds.

## Test plan
1. **Reset and first accept**: hold `rst` high for 2 cycles. All outputs are 0 and `in_ready` = 1. Issue `ALU_ADD` with rs1 = 5, rs2 = 7, `in_rd_idx` = 3. One cycle later `out_valid` = 1, `out_result` = 12, `out_rd_idx` = 3.
2. **Self-forward**: issue `ADD x3 = 5 + 7`, then immediately `SUB x4 = x3 - imm 2` with a stale `in_rs1_val` = 0 and `sel_b` = 1. The second result is 10 with the macro defined and -2 (32'hFFFFFFFE) with it undefined.
3. **Forward priority**: in the same cycle, `out` holds x5 = 1 and writeback commits x5 = 9. An instruction reading x5 uses 1. A read of x0 with `wb_rd_idx` = 0 returns `in_rs1_val`.
4. **Back-pressure**: hold `out_ready` = 0 for 3 cycles with `in_valid` = 1. `in_ready` = 0 and `out_*` stay constant. On release, the held result drains and the next result follows one cycle later with no bubble.
5. **Flush**: assert `flush` together with `in_valid` = 1 and a full slot. Next cycle `out_valid` = 0 and the presented instruction never appears.
6. **PC-relative and x0 writes**: `sel_a` = 1, `in_pc` = 32'h100, `imm` = 32'h1000, `ALU_ADD` gives `out_result` = 32'h1100. `in_rd_idx` = 0 with `in_rd_we` = 1 gives `out_rd_we` = 0.
